// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze sprite wall-collision logic.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_CELL_LOG2 = 4;

  function automatic logic [9:0] px_to_cell(input logic [9:0] px, input int shift);
    return px >> shift;
  endfunction

endpackage

// File: rtl/deny_row_mask.sv
// Combinational wall test of one wall-map row: a single column or an inclusive column range.
module deny_row_mask #(
  parameter int SIZE_X = 40,
  parameter int COL_W  = $clog2(SIZE_X)
) (
  input  logic [0:SIZE_X-1] wall_row,
  input  logic [COL_W-1:0]  lo,
  input  logic [COL_W-1:0]  hi,
  input  logic              range_mode,
  output logic              hit
);

  // OR together every selected column that carries a wall.
  always_comb begin
    hit = 1'b0;
    for (int c = 0; c < SIZE_X; c++) begin
      hit = hit | (wall_row[c] &
                   (range_mode ? ((COL_W'(c) >= lo) && (COL_W'(c) <= hi))
                               : (COL_W'(c) == lo)));
    end
  end

endmodule

// File: rtl/deny_dir_scan.sv
// Row-serial, direction-selectable wall-collision checker over an external wall-map RAM.
module deny_dir_scan
  import maze_pkg::*;
#(
  parameter int SIZE_Y    = 20,
  parameter int SIZE_X    = 40,
  parameter int CELL_LOG2 = DEF_CELL_LOG2
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         start,
  input  logic [1:0]                   dir,
  input  logic [9:0]                   top,
  input  logic [9:0]                   bottom,
  input  logic [9:0]                   left,
  input  logic [9:0]                   right,
  output logic                         wall_rd,
  output logic [2+$clog2(SIZE_Y)-1:0]  wall_addr,
  input  logic [0:SIZE_X-1]            wall_row,
  output logic                         busy,
  output logic                         done,
  output logic                         deny
);

  localparam int ROW_W = $clog2(SIZE_Y);
  localparam int COL_W = $clog2(SIZE_X);
  localparam logic [10:0] CELL_MASK = 11'((1 << CELL_LOG2) - 1);

  logic [9:0]       tr_raw_s, br_raw_s, lc_raw_s, rc_raw_s;
  logic [10:0]      right_p1_s, bottom_p1_s;
  logic [ROW_W-1:0] tr_s, br_s, first_row_s, last_row_s;
  logic [COL_W-1:0] lc_s, rc_s, lo_s, hi_s;
  logic             on_bnd_s, border_s, malformed_s, immediate_s, imm_deny_s, range_s;
  logic             hit_s;

  state_t           state_r;
  logic [1:0]       dir_r;
  logic [ROW_W-1:0] row_r, last_row_r;
  logic [COL_W-1:0] lo_r, hi_r;
  logic             range_r;

  // Decode the presented box into cells and decide between an immediate answer and a scan plan.
  always_comb begin
    tr_raw_s    = px_to_cell(top, CELL_LOG2);
    br_raw_s    = px_to_cell(bottom, CELL_LOG2);
    lc_raw_s    = px_to_cell(left, CELL_LOG2);
    rc_raw_s    = px_to_cell(right, CELL_LOG2);
    tr_s        = (tr_raw_s > 10'(SIZE_Y - 1)) ? ROW_W'(SIZE_Y - 1) : ROW_W'(tr_raw_s);
    br_s        = (br_raw_s > 10'(SIZE_Y - 1)) ? ROW_W'(SIZE_Y - 1) : ROW_W'(br_raw_s);
    lc_s        = (lc_raw_s > 10'(SIZE_X - 1)) ? COL_W'(SIZE_X - 1) : COL_W'(lc_raw_s);
    rc_s        = (rc_raw_s > 10'(SIZE_X - 1)) ? COL_W'(SIZE_X - 1) : COL_W'(rc_raw_s);
    right_p1_s  = {1'b0, right} + 11'd1;
    bottom_p1_s = {1'b0, bottom} + 11'd1;
    malformed_s = (left > right) || (top > bottom);
    on_bnd_s    = 1'b0;
    border_s    = 1'b0;
    first_row_s = tr_s;
    last_row_s  = br_s;
    lo_s        = lc_s;
    hi_s        = lc_s;
    range_s     = 1'b0;
    case (dir_t'(dir))
      DIR_RIGHT: begin
        on_bnd_s = (right_p1_s & CELL_MASK) == 11'd0;
        border_s = (rc_s == COL_W'(SIZE_X - 1));
        lo_s     = rc_s;
        hi_s     = rc_s;
      end
      DIR_LEFT: begin
        on_bnd_s = ({1'b0, left} & CELL_MASK) == 11'd0;
        border_s = (left == 10'd0);
      end
      DIR_UP: begin
        on_bnd_s   = ({1'b0, top} & CELL_MASK) == 11'd0;
        border_s   = (top == 10'd0);
        last_row_s = tr_s;
        hi_s       = rc_s;
        range_s    = 1'b1;
      end
      DIR_DOWN: begin
        on_bnd_s    = (bottom_p1_s & CELL_MASK) == 11'd0;
        border_s    = (br_s == ROW_W'(SIZE_Y - 1));
        first_row_s = br_s;
        hi_s        = rc_s;
        range_s     = 1'b1;
      end
      default: begin
        on_bnd_s = 1'b0;
        border_s = 1'b0;
      end
    endcase
    // An off-boundary edge never collides, even when the box touches the maze border.
    immediate_s = malformed_s || !on_bnd_s || border_s;
    imm_deny_s  = malformed_s || (on_bnd_s && border_s);
  end

  deny_row_mask #(
    .SIZE_X (SIZE_X),
    .COL_W  (COL_W)
  ) u_row_mask (
    .wall_row   (wall_row),
    .lo         (lo_r),
    .hi         (hi_r),
    .range_mode (range_r),
    .hit        (hit_s)
  );

  // Request sequencer: one fetch/check pair per scanned row, early exit on the first wall.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r    <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      deny       <= 1'b0;
      wall_rd    <= 1'b0;
      wall_addr  <= '0;
      dir_r      <= 2'd0;
      row_r      <= '0;
      last_row_r <= '0;
      lo_r       <= '0;
      hi_r       <= '0;
      range_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done    <= 1'b0;
          wall_rd <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            dir_r      <= dir;
            row_r      <= first_row_s;
            last_row_r <= last_row_s;
            lo_r       <= lo_s;
            hi_r       <= hi_s;
            range_r    <= range_s;
            if (immediate_s) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              deny    <= imm_deny_s;
            end else begin
              state_r   <= ST_FETCH;
              deny      <= 1'b0;
              wall_rd   <= 1'b1;
              wall_addr <= {dir, first_row_s};
            end
          end
        end
        ST_FETCH: begin
          wall_rd <= 1'b0;
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          if (hit_s) begin
            deny    <= 1'b1;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else if (row_r != last_row_r) begin
            row_r     <= row_r + ROW_W'(1);
            wall_rd   <= 1'b1;
            wall_addr <= {dir_r, row_r + ROW_W'(1)};
            state_r   <= ST_FETCH;
          end else begin
            deny    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          wall_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule
